// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: sequences start, data, optional parity and stop bits,
// enabling an external serializer during the data phase.
module uart_tx_fsm #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  accept;
    logic                  par_bit;

    assign accept  = data_valid && ((state_q == StIdle) || (state_q == StStop));
    // Odd parity is the complement of the even-parity XOR reduction.
    assign par_bit = (^data_q) ^ par_typ_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;

        case (state_q)
            StIdle: begin
                if (accept) state_d = StStart;
            end
            StStart: begin
                state_d = StData;
            end
            StData: begin
                // Counter bounds DATA even if the serializer never pulses done.
                if (ser_done || (cnt_q == CntLast)) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? StParity : StStop;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StParity: begin
                state_d = StStop;
            end
            StStop: begin
                state_d = accept ? StStart : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            data_d    = p_data;
            par_en_d  = par_en;
            par_typ_d = par_typ;
        end
    end

    always_comb begin
        tx_out = 1'b1;
        busy   = 1'b0;
        ser_en = 1'b0;
        case (state_q)
            StStart: begin
                tx_out = 1'b0;
                busy   = 1'b1;
            end
            StData: begin
                tx_out = ser_data;
                busy   = 1'b1;
                ser_en = 1'b1;
            end
            StParity: begin
                tx_out = par_bit;
                busy   = 1'b1;
            end
            StStop: begin
                busy = 1'b1;
            end
            default: begin
                tx_out = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: serializer model plus a scoreboard of expected line/enable values
// popped on every busy cycle.
module tb_uart_tx_fsm;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       data_valid = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       ser_data;
    logic       ser_done;
    logic       ser_en;
    logic       tx_out;
    logic       busy;

    typedef struct packed {
        logic tx;
        logic sen;
    } exp_t;

    exp_t       sb[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         busy_cnt = 0;
    int         sen_cnt = 0;
    logic       mon_en = 1'b0;
    logic       done_mode = 1'b1;
    logic [2:0] ser_idx;

    uart_tx_fsm #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .data_valid(data_valid),
        .p_data    (p_data),
        .par_en    (par_en),
        .par_typ   (par_typ),
        .ser_data  (ser_data),
        .ser_done  (ser_done),
        .ser_en    (ser_en),
        .tx_out    (tx_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Serializer model: LSB first, one bit per enabled cycle.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) ser_idx <= 3'd0;
        else if (ser_en) ser_idx <= ser_idx + 3'd1;
        else ser_idx <= 3'd0;
    end
    assign ser_data = p_data[ser_idx];
    assign ser_done = done_mode && ser_en && (ser_idx == 3'd7);

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && busy) begin
            busy_cnt++;
            if (ser_en) sen_cnt++;
            chk("sb_nonempty", 16'(sb.size() != 0), 16'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("tx_out", 16'(tx_out), 16'(e.tx));
                chk("ser_en", 16'(ser_en), 16'(e.sen));
            end
        end
    end

    task automatic push_frame(input logic [7:0] d, input logic pen, input logic ptyp);
        logic pb;
        pb = 1'b0;
        for (int i = 0; i < 8; i++) pb = pb ^ d[i];
        if (ptyp) pb = ~pb;
        sb.push_back('{tx: 1'b0, sen: 1'b0});
        for (int i = 0; i < 8; i++) sb.push_back('{tx: d[i], sen: 1'b1});
        if (pen) sb.push_back('{tx: pb, sen: 1'b0});
        sb.push_back('{tx: 1'b1, sen: 1'b0});
    endtask

    // Called at a negedge; returns one cycle after the accepting edge.
    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp);
        p_data     = d;
        par_en     = pen;
        par_typ    = ptyp;
        data_valid = 1'b1;
        push_frame(d, pen, ptyp);
        @(negedge clk);
        data_valid = 1'b0;
        // Flipping the options mid-frame must not disturb the latched copy.
        par_en     = ~pen;
        par_typ    = ~ptyp;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 16'(n < 40), 16'd1);
        chk({tag, "_sb_drained"}, 16'(sb.size()), 16'd0);
        sb.delete();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_tx"}, 16'(tx_out), 16'd1);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        chk({tag, "_ser_en"}, 16'(ser_en), 16'd0);
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(negedge clk);
        check_idle("reset");
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("idle");
        end
        mon_en = 1'b1;

        // 0xA5, no parity: 10-cycle frame, 8 enable cycles
        busy_cnt = 0;
        sen_cnt  = 0;
        send(8'hA5, 1'b0, 1'b0);
        wait_idle("a5_nopar");
        chk("a5_busy_cycles", 16'(busy_cnt), 16'd10);
        chk("a5_ser_en_cycles", 16'(sen_cnt), 16'd8);
        check_idle("after_a5");

        // Parity variants
        busy_cnt = 0;
        send(8'hA5, 1'b1, 1'b0);
        wait_idle("a5_even");
        chk("a5_even_busy_cycles", 16'(busy_cnt), 16'd11);
        send(8'hA5, 1'b1, 1'b1);
        wait_idle("a5_odd");
        send(8'h01, 1'b1, 1'b1);
        wait_idle("01_odd");

        // Back-to-back with a pulse during DATA that must be ignored
        send(8'hA5, 1'b0, 1'b0);
        par_en  = 1'b0;
        repeat (2) @(negedge clk);
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("b2b_in_stop_tx", 16'(tx_out), 16'd1);
        send(8'h3C, 1'b0, 1'b0);
        chk("b2b_no_gap_busy", 16'(busy), 16'd1);
        chk("b2b_no_gap_start", 16'(tx_out), 16'd0);
        wait_idle("b2b");

        // Missing done pulse: counter guard gives identical timing
        done_mode = 1'b0;
        busy_cnt  = 0;
        send(8'h96, 1'b1, 1'b0);
        wait_idle("no_done");
        chk("no_done_busy_cycles", 16'(busy_cnt), 16'd11);
        done_mode = 1'b1;

        // Asynchronous reset mid-DATA
        send(8'h5A, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check_idle("async_rst");
        sb.delete();
        repeat (2) @(negedge clk);
        check_idle("in_rst");
        rstn = 1'b1;
        @(negedge clk);
        check_idle("post_rst");
        mon_en   = 1'b1;
        busy_cnt = 0;
        send(8'hC3, 1'b1, 1'b1);
        wait_idle("post_rst_frame");
        chk("post_rst_busy_cycles", 16'(busy_cnt), 16'd11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
